// File: rtl/board_lock_ctl_pkg.sv
// Shared playfield definitions: board geometry defaults, lock-sequence states
// and the block codes agreed with the falling-piece controller.
package board_lock_ctl_pkg;

  localparam int BOARD_COLS    = 10;
  localparam int BOARD_ROWS    = 20;
  localparam int BOARD_LINES_W = 16;
  localparam int NUM_SQ        = 4;

  typedef logic [3:0] sq_col_t;
  typedef logic [4:0] sq_row_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCK  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } lock_state_t;

  typedef enum logic [2:0] {
    BLK_I = 3'd0,
    BLK_O = 3'd1,
    BLK_T = 3'd2,
    BLK_S = 3'd3,
    BLK_Z = 3'd4,
    BLK_J = 3'd5,
    BLK_L = 3'd6
  } block_t;

endpackage

// File: rtl/board_lock_ctl_cell_probe.sv
// Combinational lookup of four piece squares against the grid, shifted down by
// row_ofs rows; a square "hits" when out of bounds or (optionally) occupied.
module board_lock_ctl_cell_probe
  import board_lock_ctl_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter int ROWS = BOARD_ROWS
) (
  input  logic [COLS-1:0]   grid [ROWS],
  input  sq_col_t           sq_col [NUM_SQ],
  input  sq_row_t           sq_row [NUM_SQ],
  input  logic              row_ofs,
  input  logic              check_occ,
  output logic [NUM_SQ-1:0] hit
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SQ; gi++) begin : g_sq
      logic [5:0] row_sum;
      logic [4:0] row_idx;
      logic       oob;
      logic       occ;

      assign row_sum = {1'b0, sq_row[gi]} + {5'b0, row_ofs};
      assign row_idx = row_sum[4:0];
      assign oob     = (int'(row_sum) >= ROWS) || (int'(sq_col[gi]) >= COLS);
      // The grid is only indexed once the square is known to be in range.
      assign occ     = !oob && grid[row_idx][sq_col[gi]];
      assign hit[gi] = oob || (check_occ && occ);
    end
  endgenerate

endmodule

// File: rtl/board_lock_ctl.sv
// Playfield stage: commits locked pieces into the occupancy grid, clears full
// rows bottom-up, tracks line totals / game over and serves collision + render reads.
module board_lock_ctl
  import board_lock_ctl_pkg::*;
#(
  parameter int COLS    = BOARD_COLS,
  parameter int ROWS    = BOARD_ROWS,
  parameter int LINES_W = BOARD_LINES_W
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               lock_en,
  input  logic [3:0]         sq_1_col,
  input  logic [3:0]         sq_2_col,
  input  logic [3:0]         sq_3_col,
  input  logic [3:0]         sq_4_col,
  input  logic [4:0]         sq_1_row,
  input  logic [4:0]         sq_2_row,
  input  logic [4:0]         sq_3_row,
  input  logic [4:0]         sq_4_row,
  input  logic [4:0]         rd_row,
  output logic [COLS-1:0]    rd_data,
  output logic               collision,
  output logic               busy,
  output logic               lines_valid,
  output logic [2:0]         lines_cleared,
  output logic [LINES_W-1:0] total_lines,
  output logic               game_over
);

  localparam sq_row_t         LAST_ROW = sq_row_t'(ROWS - 1);
  localparam logic [COLS-1:0] COL_ONE  = {{(COLS - 1){1'b0}}, 1'b1};

  lock_state_t        state_reg, state_next;
  logic [COLS-1:0]    grid_reg [ROWS];
  sq_row_t            scan_row_reg;
  logic [2:0]         clr_cnt_reg;
  logic [LINES_W-1:0] total_lines_reg;
  logic [LINES_W:0]   total_sum;
  logic               game_over_reg;
  logic               collision_reg;
  logic [COLS-1:0]    rd_data_reg;

  sq_col_t            sq_col [NUM_SQ];
  sq_row_t            sq_row [NUM_SQ];
  logic [NUM_SQ-1:0]  below_hit;
  logic [NUM_SQ-1:0]  bounds_hit;
  logic [NUM_SQ-1:0]  lock_ok;
  logic [NUM_SQ-1:0]  top_row;
  logic               scan_full;

  assign sq_col[0] = sq_1_col;
  assign sq_col[1] = sq_2_col;
  assign sq_col[2] = sq_3_col;
  assign sq_col[3] = sq_4_col;
  assign sq_row[0] = sq_1_row;
  assign sq_row[1] = sq_2_row;
  assign sq_row[2] = sq_3_row;
  assign sq_row[3] = sq_4_row;

  board_lock_ctl_cell_probe #(.COLS(COLS), .ROWS(ROWS)) u_below_probe (
    .grid      (grid_reg),
    .sq_col    (sq_col),
    .sq_row    (sq_row),
    .row_ofs   (1'b1),
    .check_occ (1'b1),
    .hit       (below_hit)
  );

  // Same probe with no offset and no occupancy term gives a pure bounds check.
  board_lock_ctl_cell_probe #(.COLS(COLS), .ROWS(ROWS)) u_bounds_probe (
    .grid      (grid_reg),
    .sq_col    (sq_col),
    .sq_row    (sq_row),
    .row_ofs   (1'b0),
    .check_occ (1'b0),
    .hit       (bounds_hit)
  );

  assign lock_ok   = ~bounds_hit;
  assign scan_full = &grid_reg[scan_row_reg];
  assign total_sum = {1'b0, total_lines_reg} + (LINES_W + 1)'(clr_cnt_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SQ; gi++) begin : g_top
      assign top_row[gi] = (sq_row[gi] == 5'd0);
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [COLS-1:0] row_lock_mask;
      logic [COLS-1:0] row_above;

      if (gi == 0) begin : g_first
        assign row_above = '0;
      end else begin : g_rest
        assign row_above = grid_reg[gi - 1];
      end

      always_comb begin
        row_lock_mask = '0;
        for (int i = 0; i < NUM_SQ; i++) begin
          if (lock_ok[i] && (sq_row[i] == 5'(gi)))
            row_lock_mask = row_lock_mask | (COL_ONE << sq_col[i]);
        end
      end

      // Rows at or above the scan row drop by one during SHIFT.
      always_ff @(posedge pclk) begin
        if (rst)
          grid_reg[gi] <= '0;
        else if (state_reg == ST_LOCK)
          grid_reg[gi] <= grid_reg[gi] | row_lock_mask;
        else if ((state_reg == ST_SHIFT) && (5'(gi) <= scan_row_reg))
          grid_reg[gi] <= row_above;
      end
    end
  endgenerate

  always_ff @(posedge pclk) begin
    if (rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (lock_en) state_next = ST_LOCK;
      ST_LOCK:  state_next = ST_SCAN;
      ST_SCAN: begin
        if (scan_full)
          state_next = ST_SHIFT;
        else if (scan_row_reg == 5'd0)
          state_next = ST_DONE;
      end
      ST_SHIFT: state_next = ST_SCAN;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_reg != ST_IDLE);
    lines_valid   = (state_reg == ST_DONE);
    lines_cleared = (state_reg == ST_DONE) ? clr_cnt_reg : 3'd0;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      scan_row_reg    <= '0;
      clr_cnt_reg     <= '0;
      total_lines_reg <= '0;
      game_over_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOCK: begin
          scan_row_reg <= LAST_ROW;
          clr_cnt_reg  <= '0;
          if (|(lock_ok & top_row))
            game_over_reg <= 1'b1;
        end
        ST_SCAN: begin
          if (!scan_full && (scan_row_reg != 5'd0))
            scan_row_reg <= scan_row_reg - 5'd1;
        end
        ST_SHIFT: clr_cnt_reg <= clr_cnt_reg + 3'd1;
        ST_DONE: begin
          if (total_sum[LINES_W])
            total_lines_reg <= '1;
          else
            total_lines_reg <= total_sum[LINES_W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      collision_reg <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      collision_reg <= |below_hit;
      rd_data_reg   <= (int'(rd_row) < ROWS) ? grid_reg[rd_row] : '0;
    end
  end

  assign collision   = collision_reg;
  assign rd_data     = rd_data_reg;
  assign total_lines = total_lines_reg;
  assign game_over   = game_over_reg;

endmodule

// File: tb/tb_board_lock_ctl.sv
// Self-checking bench for board_lock_ctl: directed lock/clear/reset scenarios,
// a collision vector table and random locks against a gravity-compaction model.
module tb_board_lock_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        lock_en = 1'b0;
  logic [3:0]  sq_1_col, sq_2_col, sq_3_col, sq_4_col;
  logic [4:0]  sq_1_row, sq_2_row, sq_3_row, sq_4_row;
  logic [4:0]  rd_row = 5'd0;
  logic [9:0]  rd_data;
  logic        collision, busy, lines_valid, game_over;
  logic [2:0]  lines_cleared;
  logic [15:0] total_lines;

  board_lock_ctl dut (
    .pclk          (pclk),
    .rst           (rst),
    .lock_en       (lock_en),
    .sq_1_col      (sq_1_col),
    .sq_2_col      (sq_2_col),
    .sq_3_col      (sq_3_col),
    .sq_4_col      (sq_4_col),
    .sq_1_row      (sq_1_row),
    .sq_2_row      (sq_2_row),
    .sq_3_row      (sq_3_row),
    .sq_4_row      (sq_4_row),
    .rd_row        (rd_row),
    .rd_data       (rd_data),
    .collision     (collision),
    .busy          (busy),
    .lines_valid   (lines_valid),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines),
    .game_over     (game_over)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  bit model_grid [20][10];
  int model_total;
  bit model_go;
  int m_r [4];
  int m_c [4];

  typedef struct packed {
    logic [4:0] r0, r1, r2, r3;
    logic [3:0] c0, c1, c2, c3;
    logic       exp_coll;
  } coll_vec_t;
  coll_vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic assign_sq(input int r0, input int c0, input int r1, input int c1,
                           input int r2, input int c2, input int r3, input int c3);
    m_r[0] = r0; m_r[1] = r1; m_r[2] = r2; m_r[3] = r3;
    m_c[0] = c0; m_c[1] = c1; m_c[2] = c2; m_c[3] = c3;
    sq_1_row = 5'(r0); sq_2_row = 5'(r1); sq_3_row = 5'(r2); sq_4_row = 5'(r3);
    sq_1_col = 4'(c0); sq_2_col = 4'(c1); sq_3_col = 4'(c2); sq_4_col = 4'(c3);
  endtask

  task automatic set_sq(input int r0, input int c0, input int r1, input int c1,
                        input int r2, input int c2, input int r3, input int c3);
    @(negedge pclk);
    assign_sq(r0, c0, r1, c1, r2, c2, r3, c3);
  endtask

  function automatic logic [9:0] model_row(input int r);
    logic [9:0] v = '0;
    for (int c = 0; c < 10; c++) v[c] = model_grid[r][c];
    return v;
  endfunction

  function automatic logic model_collision();
    for (int i = 0; i < 4; i++) begin
      if (m_r[i] >= 19 || m_c[i] >= 10) return 1'b1;
      if (model_grid[m_r[i] + 1][m_c[i]]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Commit squares, then drop every non-full row to the bottom in order.
  task automatic model_lock(output int cleared);
    bit tmp [20][10];
    int k;
    bit full;
    for (int i = 0; i < 4; i++) begin
      if (m_r[i] < 20 && m_c[i] < 10) begin
        model_grid[m_r[i]][m_c[i]] = 1'b1;
        if (m_r[i] == 0) model_go = 1'b1;
      end
    end
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) tmp[r][c] = 1'b0;
    k = 19;
    cleared = 0;
    for (int r = 19; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < 10; c++) if (!model_grid[r][c]) full = 1'b0;
      if (full) cleared++;
      else begin
        tmp[k] = model_grid[r];
        k--;
      end
    end
    model_grid = tmp;
    model_total = (model_total + cleared > 65535) ? 65535 : model_total + cleared;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) model_grid[r][c] = 1'b0;
    model_total = 0;
    model_go = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1;
    lock_en = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("rst_busy", 32'(busy), 0);
    check("rst_lines_valid", 32'(lines_valid), 0);
    check("rst_lines_cleared", 32'(lines_cleared), 0);
    check("rst_total_lines", 32'(total_lines), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_collision", 32'(collision), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_lock(output int nclr, output int nbusy, output int nvalid);
    @(negedge pclk);
    lock_en = 1'b1;
    @(negedge pclk);
    lock_en = 1'b0;
    nbusy = 0;
    nvalid = 0;
    nclr = -1;
    while (busy && nbusy < 200) begin
      nbusy++;
      if (lines_valid) begin
        nvalid++;
        nclr = int'(lines_cleared);
      end
      @(negedge pclk);
    end
    if (busy) check("lock_timeout_busy", 32'(busy), 0);
  endtask

  task automatic read_row(input int r, output logic [9:0] d);
    @(negedge pclk);
    rd_row = 5'(r);
    @(negedge pclk);
    d = rd_data;
  endtask

  task automatic check_grid(input string name);
    logic [9:0] d;
    int bad = 0;
    for (int r = 0; r < 20; r++) begin
      read_row(r, d);
      checks++;
      if (d !== model_row(r)) begin
        errors++;
        bad++;
        $display("FAIL %s row %0d: got %b expected %b", name, r, d, model_row(r));
      end
    end
  endtask

  // Lock the current squares and compare the sequence outcome with the model.
  task automatic lock_and_check(input string name);
    int nclr, nbusy, nvalid, exp_clr;
    do_lock(nclr, nbusy, nvalid);
    model_lock(exp_clr);
    check({name, "_valid_pulses"}, 32'(nvalid), 1);
    check({name, "_lines_cleared"}, 32'(nclr), 32'(exp_clr));
    check({name, "_total_lines"}, 32'(total_lines), 32'(model_total));
    check({name, "_game_over"}, 32'(game_over), 32'(model_go));
    if (exp_clr == 0) check({name, "_busy_cycles"}, 32'(nbusy), 22);
    $display("lock %s: sq=(%0d,%0d)(%0d,%0d)(%0d,%0d)(%0d,%0d) cleared=%0d total=%0d busy=%0d go=%0d",
             name, m_r[0], m_c[0], m_r[1], m_c[1], m_r[2], m_c[2], m_r[3], m_c[3],
             nclr, total_lines, nbusy, game_over);
  endtask

  initial begin
    logic [9:0] d;
    int nclr, nbusy, nvalid, nb, nv, mode, r, c, dummy;

    tbl[0] = '{5'd0,  5'd1,  5'd2,  5'd3,  4'd5, 4'd5, 4'd5, 4'd5,  1'b0};
    tbl[1] = '{5'd17, 5'd18, 5'd18, 5'd18, 4'd0, 4'd0, 4'd1, 4'd2,  1'b1};
    tbl[2] = '{5'd18, 5'd18, 5'd18, 5'd18, 4'd4, 4'd5, 4'd6, 4'd7,  1'b0};
    tbl[3] = '{5'd5,  5'd5,  5'd5,  5'd19, 4'd0, 4'd1, 4'd2, 4'd8,  1'b1};
    tbl[4] = '{5'd0,  5'd0,  5'd0,  5'd0,  4'd5, 4'd6, 4'd7, 4'd10, 1'b1};
    tbl[5] = '{5'd18, 5'd0,  5'd0,  5'd0,  4'd3, 4'd5, 4'd5, 4'd5,  1'b1};
    tbl[6] = '{5'd17, 5'd17, 5'd17, 5'd17, 4'd0, 4'd1, 4'd2, 4'd3,  1'b0};
    tbl[7] = '{5'd10, 5'd10, 5'd10, 5'd10, 4'd9, 4'd9, 4'd9, 4'd15, 1'b1};
    tbl[8] = '{5'd18, 5'd18, 5'd18, 5'd18, 4'd9, 4'd9, 4'd9, 4'd9,  1'b0};
    tbl[9] = '{5'd20, 5'd0,  5'd0,  5'd0,  4'd0, 4'd5, 4'd5, 4'd5,  1'b1};

    assign_sq(0, 5, 1, 5, 2, 5, 3, 5);
    do_reset();

    // Empty board after reset, including out-of-range render rows.
    for (int rr = 0; rr < 32; rr++) begin
      read_row(rr, d);
      check($sformatf("empty_row_%0d", rr), 32'(d), 0);
    end
    set_sq(0, 5, 1, 5, 2, 5, 3, 5);
    @(negedge pclk);
    check("empty_collision", 32'(collision), 0);

    // Floor collision then lock on the bottom row.
    set_sq(19, 0, 19, 1, 19, 2, 19, 3);
    @(negedge pclk);
    check("floor_collision", 32'(collision), 1);
    do_lock(nclr, nbusy, nvalid);
    model_lock(dummy);
    check("floor_busy_cycles", 32'(nbusy), 22);
    check("floor_valid_pulses", 32'(nvalid), 1);
    check("floor_lines_cleared", 32'(nclr), 0);
    read_row(19, d);
    check("floor_row19", 32'(d), 32'(10'b0000001111));
    $display("lock floor: busy=%0d cleared=%0d row19=%b", nbusy, nclr, d);

    for (int i = 0; i < 10; i++) begin
      set_sq(int'(tbl[i].r0), int'(tbl[i].c0), int'(tbl[i].r1), int'(tbl[i].c1),
             int'(tbl[i].r2), int'(tbl[i].c2), int'(tbl[i].r3), int'(tbl[i].c3));
      @(negedge pclk);
      check($sformatf("coll_vec_%0d", i), 32'(collision), 32'(tbl[i].exp_coll));
      $display("coll vec %0d: got %0d want %0d", i, collision, tbl[i].exp_coll);
    end

    // Two nearly-full rows completed by a vertical I in column 9.
    do_reset();
    set_sq(19, 0, 19, 1, 19, 2, 19, 3);  lock_and_check("pre1");
    set_sq(19, 4, 19, 5, 19, 6, 19, 7);  lock_and_check("pre2");
    set_sq(19, 8, 18, 0, 18, 1, 18, 2);  lock_and_check("pre3");
    set_sq(18, 3, 18, 4, 18, 5, 18, 6);  lock_and_check("pre4");
    set_sq(18, 7, 18, 8, 18, 8, 18, 8);  lock_and_check("pre5");
    set_sq(16, 9, 17, 9, 18, 9, 19, 9);
    do_lock(nclr, nbusy, nvalid);
    model_lock(dummy);
    check("i_lines_cleared", 32'(nclr), 2);
    check("i_valid_pulses", 32'(nvalid), 1);
    check("i_total_lines", 32'(total_lines), 2);
    read_row(19, d);
    check("i_row19", 32'(d), 32'(10'b1000000000));
    read_row(18, d);
    check("i_row18", 32'(d), 32'(10'b1000000000));
    check_grid("i_grid");
    $display("lock vertical_i: cleared=%0d total=%0d busy=%0d", nclr, total_lines, nbusy);

    // Reset while the full bottom row is being shifted out.
    set_sq(19, 0, 19, 1, 19, 2, 19, 3);  lock_and_check("fill1");
    set_sq(19, 4, 19, 5, 19, 6, 19, 7);  lock_and_check("fill2");
    set_sq(19, 8, 19, 8, 19, 8, 19, 8);
    @(negedge pclk);
    lock_en = 1'b1;
    @(negedge pclk);
    lock_en = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("shift_busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    check("shift_rst_busy", 32'(busy), 0);
    check("shift_rst_total", 32'(total_lines), 0);
    check("shift_rst_game_over", 32'(game_over), 0);
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      if (lines_valid || busy) nv++;
      @(negedge pclk);
    end
    check("shift_rst_no_activity", 32'(nv), 0);
    model_reset();
    check_grid("shift_rst_grid");
    $display("reset during shift: busy=%0d total=%0d", busy, total_lines);

    // Top-row lock raises game_over, which survives later locks.
    set_sq(0, 5, 1, 5, 2, 5, 3, 5);      lock_and_check("top");
    check("go_set", 32'(game_over), 1);
    set_sq(19, 0, 19, 1, 19, 2, 19, 3);  lock_and_check("after_go");
    check("go_sticky", 32'(game_over), 1);

    // A second lock_en three cycles into a sequence is dropped.
    set_sq(19, 4, 19, 5, 19, 6, 19, 7);
    model_lock(dummy);
    @(negedge pclk);
    lock_en = 1'b1;
    nb = 0;
    nv = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge pclk);
      if (busy) nb++;
      if (lines_valid) nv++;
      lock_en = (k == 3);
      if (k == 3) assign_sq(5, 0, 5, 1, 5, 2, 5, 3);
    end
    check("ignore_busy_cycles", 32'(nb), 22);
    check("ignore_valid_pulses", 32'(nv), 1);
    read_row(5, d);
    check("ignore_row5", 32'(d), 0);
    check_grid("ignore_grid");
    $display("lock while busy: busy_cycles=%0d valid_pulses=%0d", nb, nv);

    // Random pieces against the compaction model.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      mode = int'($urandom_range(0, 9));
      if (mode <= 4) begin
        r = int'($urandom_range(14, 19));
        c = int'($urandom_range(0, 6));
        set_sq(r, c, r, c + 1, r, c + 2, r, c + 3);
      end else if (mode <= 7) begin
        r = int'($urandom_range(12, 16));
        c = int'($urandom_range(0, 9));
        set_sq(r, c, r + 1, c, r + 2, c, r + 3, c);
      end else if (mode == 8) begin
        r = int'($urandom_range(0, 18));
        c = int'($urandom_range(0, 8));
        set_sq(r, c, r, c + 1, r + 1, c, r + 1, c + 1);
      end else begin
        set_sq(int'($urandom_range(20, 31)), int'($urandom_range(0, 9)),
               int'($urandom_range(15, 19)), int'($urandom_range(10, 15)),
               int'($urandom_range(15, 19)), int'($urandom_range(0, 9)),
               int'($urandom_range(15, 19)), int'($urandom_range(0, 9)));
      end
      lock_and_check($sformatf("rand%0d", t));
      check_grid($sformatf("rand%0d_grid", t));
      set_sq(int'($urandom_range(0, 19)), int'($urandom_range(0, 11)),
             int'($urandom_range(0, 19)), int'($urandom_range(0, 9)),
             int'($urandom_range(0, 19)), int'($urandom_range(0, 9)),
             int'($urandom_range(0, 19)), int'($urandom_range(0, 9)));
      @(negedge pclk);
      check($sformatf("rand%0d_collision", t), 32'(collision), 32'(model_collision()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
